runtime_config_regs: RTL and testbench
======================================

Name: runtime_config_regs

Overview:
- Runtime-writable configuration register bank; successor to the compile-time-only config parameters.
- Host writes new settings through the OCL slave path into a shadow bank. A COMMIT write freezes all tiles, waits for every tile to report quiescent, then copies shadow to active atomically.
- Supplies active settings to tiles (CQ sizing, logging/stats masks, GVT period).
- Commit aborts on timeout and sets a sticky error bit.

Parameters:
- N_TILES, 1, number of tiles supplying idle and receiving freeze.
- N_CFG_REGS, 8, number of shadow/active config words.
- REG_WIDTH, 32, width of each config word and of the data bus.
- ADDR_WIDTH, 6, word-index address width; must satisfy 4+N_CFG_REGS <= 2^ADDR_WIDTH.
- CFG_VERSION, 10, constant returned at index 0.
- TIMEOUT_W, 16, width of the drain timeout counter.
- RESET_VALUES, all zero, N_CFG_REGS*REG_WIDTH reset image loaded into shadow and active.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word index.
- req_wdata  in  REG_WIDTH  write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed.
- resp_rdata  out  REG_WIDTH  read data; 0 for writes.
- resp_err  out  1  illegal access.
- tile_idle  in  N_TILES  per-tile quiescent indication.
- cfg_freeze  out  1  tiles must stop dequeuing and drain.
- cfg_update  out  1  one-cycle pulse when active values change.
- cfg_active  out  N_CFG_REGS*REG_WIDTH  active bank, word i at bits [i*REG_WIDTH +: REG_WIDTH].
- commit_busy  out  1  FSM not in IDLE.

Behaviour:
- Address map:
  - 0 VERSION: read-only, returns CFG_VERSION.
  - 1 STATUS: read-only. bits[1:0] FSM state; bit2 sticky timeout error; bits[15:8] commit generation count (8-bit, wraps 255->0); other bits 0.
  - 2 COMMIT: write-only. req_wdata[TIMEOUT_W-1:0] is the drain timeout in cycles; 0 means no timeout. Reads return 0 with resp_err=1.
  - 3: reserved.
  - 4..4+N_CFG_REGS-1: shadow registers, read/write.
- Illegal accesses: any index beyond the map, writes to 0/1/3, and reads of 2/3 give resp_err=1 and have no side effect.
- Handshake:
  - One outstanding request at a time.
  - req_ready = !resp_valid || resp_ready, additionally gated low for all writes while commit_busy. Reads are always accepted under the resp rule.
  - Response appears the cycle after acceptance. It holds until resp_ready is high.
- Shadow write: takes effect on the acceptance edge; the read in the next cycle returns the new value.
- FSM:
  - IDLE: accepted COMMIT write loads the timeout counter, clears nothing, and goes to DRAIN.
  - DRAIN: cfg_freeze=1.
    - If &tile_idle, go to APPLY. Tile idle is sampled the same cycle; idle tiles on entry still spend one DRAIN cycle.
    - Otherwise, if the timeout is nonzero, decrement the counter. On reaching 0, set the sticky error and go to IDLE; shadow and active are unchanged.
  - APPLY: active <= shadow, generation++, then DONE. cfg_freeze stays 1.
  - DONE: cfg_update=1 for exactly this cycle; cfg_freeze=1; next state IDLE, where freeze drops.
- Sticky error clears only on reset or at the next successful APPLY.
- Simultaneous tile_idle and timeout expiry in the same DRAIN cycle: idle wins, go to APPLY.
- A tile_idle that deasserts mid-DRAIN restarts nothing; the counter keeps running.
- Reset:
  - Reset of all outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, cfg_freeze=0, cfg_update=0, commit_busy=0.
  - cfg_active and shadow = RESET_VALUES; generation=0; error=0; FSM=IDLE.
  - Reset mid-DRAIN or mid-APPLY aborts immediately to the reset state.

Decomposition:
- Shared package: address-index constants (VERSION/STATUS/COMMIT/CFG_BASE), the FSM state enum, the STATUS field positions, and a cfg-word index enum naming each active word (CQ size, logging mask, stats mask, GVT period).
- One sub-module, cfg_commit_fsm: the drain/apply/timeout state machine, with idle AND-reduction and the counter.
- The register file and request path stay in the top.

Test Plan:
- Reset, then read idx 0 -> resp_rdata=10, resp_err=0; read idx 4 -> RESET_VALUES word 0.
- Write 0xA5A5_0001 to idx 5, read idx 5 -> 0xA5A5_0001; cfg_active word 1 unchanged.
- tile_idle=all 1, write COMMIT=0 -> freeze for DRAIN+APPLY+DONE = 3 cycles; cfg_update one pulse; word 1 = 0xA5A5_0001; STATUS gen=1.
- tile_idle=0, COMMIT=5 -> error bit set after 5 DRAIN decrements; active unchanged; a write to idx 4 during DRAIN sees req_ready=0.
- Write to idx 1, read idx 2, and access idx 63 -> resp_err=1, no state change; hold resp_ready=0 for 4 cycles -> req_ready=0 and resp is held stable.
- 256 successful commits -> gen wraps to 0; assert rst during DRAIN -> freeze=0 next cycle, active = RESET_VALUES.

Source files
------------

// File: rtl/runtime_config_regs_pkg.sv
// Shared definitions for the runtime configuration bank: address map, commit FSM
// states, STATUS layout and names of the active config words.
package runtime_config_regs_pkg;

  localparam int IDX_VERSION  = 0;
  localparam int IDX_STATUS   = 1;
  localparam int IDX_COMMIT   = 2;
  localparam int IDX_CFG_BASE = 4;

  localparam int ST_STATE_LSB = 0;
  localparam int ST_ERR_BIT   = 2;
  localparam int ST_GEN_LSB   = 8;
  localparam int ST_GEN_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_APPLY = 2'd2,
    ST_DONE  = 2'd3
  } commit_state_e;

  typedef enum int {
    CFG_CQ_SIZE    = 0,
    CFG_LOG_MASK   = 1,
    CFG_STATS_MASK = 2,
    CFG_GVT_PERIOD = 3
  } cfg_word_e;

  typedef struct packed {
    logic is_version;
    logic is_status;
    logic is_commit;
    logic in_cfg;
    logic illegal;
  } req_dec_t;

  function automatic logic [31:0] status_word(input commit_state_e st, input logic err,
                                              input logic [ST_GEN_W-1:0] gen);
    logic [31:0] w;
    w = '0;
    w[ST_STATE_LSB +: 2]     = st;
    w[ST_ERR_BIT]            = err;
    w[ST_GEN_LSB +: ST_GEN_W] = gen;
    return w;
  endfunction

endpackage

// File: rtl/runtime_config_regs_cfg_commit_fsm.sv
// Commit sequencer: freezes tiles, waits for all of them to go idle (with an
// optional drain timeout), then triggers the shadow->active copy.
module cfg_commit_fsm
  import runtime_config_regs_pkg::*;
#(
  parameter int N_TILES   = 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic [N_TILES-1:0]  tile_idle,
  output commit_state_e       state,
  output logic                freeze,
  output logic                update,
  output logic                busy,
  output logic                apply,
  output logic                err,
  output logic [ST_GEN_W-1:0] gen
);

  logic [TIMEOUT_W-1:0] cnt;
  logic                 tmo_en;
  logic                 all_idle;

  assign all_idle = &tile_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      freeze <= 1'b0;
      update <= 1'b0;
      busy   <= 1'b0;
      apply  <= 1'b0;
      err    <= 1'b0;
      gen    <= '0;
      cnt    <= '0;
      tmo_en <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_DRAIN;
          cnt    <= timeout;
          tmo_en <= |timeout;
          freeze <= 1'b1;
          busy   <= 1'b1;
        end
        // Idle takes priority over an expiring counter in the same cycle.
        ST_DRAIN: if (all_idle) begin
          state <= ST_APPLY;
          apply <= 1'b1;
        end else if (tmo_en) begin
          cnt <= cnt - TIMEOUT_W'(1);
          if (cnt == TIMEOUT_W'(1)) begin
            state  <= ST_IDLE;
            err    <= 1'b1;
            freeze <= 1'b0;
            busy   <= 1'b0;
          end
        end
        ST_APPLY: begin
          state  <= ST_DONE;
          apply  <= 1'b0;
          update <= 1'b1;
          gen    <= gen + ST_GEN_W'(1);
          err    <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          freeze <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/runtime_config_regs.sv
// Runtime-writable config bank: host request path, shadow/active word storage
// and the commit sequencer that swaps shadow into active atomically.
module runtime_config_regs
  import runtime_config_regs_pkg::*;
#(
  parameter int N_TILES     = 1,
  parameter int N_CFG_REGS  = 8,
  parameter int REG_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int CFG_VERSION = 10,
  parameter int TIMEOUT_W   = 16,
  parameter logic [N_CFG_REGS*REG_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [REG_WIDTH-1:0]            req_wdata,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [REG_WIDTH-1:0]            resp_rdata,
  output logic                            resp_err,
  input  logic [N_TILES-1:0]              tile_idle,
  output logic                            cfg_freeze,
  output logic                            cfg_update,
  output logic [N_CFG_REGS*REG_WIDTH-1:0] cfg_active,
  output logic                            commit_busy
);

  localparam int IW = (N_CFG_REGS > 1) ? $clog2(N_CFG_REGS) : 1;

  logic [N_CFG_REGS-1:0][REG_WIDTH-1:0] shadow, active;
  commit_state_e        state;
  logic                 cfg_err, apply, accept, commit_start;
  logic [ST_GEN_W-1:0]  gen;
  logic [31:0]          addr_i;
  logic [IW-1:0]        widx;
  logic [REG_WIDTH-1:0] rd_mux;
  req_dec_t             dec;

  // Writes stall while a commit is in flight; reads keep flowing.
  assign req_ready    = (!resp_valid || resp_ready) && !(req_write && commit_busy);
  assign accept       = req_valid && req_ready;
  assign commit_start = accept && req_write && dec.is_commit;

  assign addr_i = 32'(req_addr);
  assign widx   = IW'(addr_i - 32'(IDX_CFG_BASE));

  always_comb begin
    dec            = '0;
    dec.is_version = addr_i == 32'(IDX_VERSION);
    dec.is_status  = addr_i == 32'(IDX_STATUS);
    dec.is_commit  = addr_i == 32'(IDX_COMMIT);
    dec.in_cfg     = (addr_i >= 32'(IDX_CFG_BASE)) && (addr_i < 32'(IDX_CFG_BASE + N_CFG_REGS));
    dec.illegal    = req_write ? !(dec.is_commit || dec.in_cfg)
                               : !(dec.is_version || dec.is_status || dec.in_cfg);
  end

  always_comb begin
    rd_mux = '0;
    if (dec.is_version)     rd_mux = REG_WIDTH'(CFG_VERSION);
    else if (dec.is_status) rd_mux = REG_WIDTH'(status_word(state, cfg_err, gen));
    else if (dec.in_cfg)    rd_mux = shadow[widx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= dec.illegal;
      resp_rdata <= (req_write || dec.illegal) ? '0 : rd_mux;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CFG_REGS; i++) begin : g_word
    logic [REG_WIDTH-1:0] sh_q, act_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sh_q  <= RESET_VALUES[i*REG_WIDTH +: REG_WIDTH];
        act_q <= RESET_VALUES[i*REG_WIDTH +: REG_WIDTH];
      end else begin
        if (accept && req_write && dec.in_cfg && widx == IW'(i)) sh_q <= req_wdata;
        if (apply) act_q <= sh_q;
      end
    end
    assign shadow[i] = sh_q;
    assign active[i] = act_q;
  end

  assign cfg_active = active;

  cfg_commit_fsm #(
    .N_TILES   (N_TILES),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (commit_start),
    .timeout   (req_wdata[TIMEOUT_W-1:0]),
    .tile_idle (tile_idle),
    .state     (state),
    .freeze    (cfg_freeze),
    .update    (cfg_update),
    .busy      (commit_busy),
    .apply     (apply),
    .err       (cfg_err),
    .gen       (gen)
  );

endmodule

// File: tb/tb_runtime_config_regs.sv
// Directed bench for runtime_config_regs with a transaction-level reference model
// checked every cycle, plus literal expectations for the main scenarios.
module tb_runtime_config_regs;

  localparam logic [255:0] RV = {32'h1000_0007, 32'h1000_0006, 32'h1000_0005, 32'h1000_0004,
                                 32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};

  logic         clk = 0, rst = 1;
  logic         req_valid = 0, req_write = 0, resp_ready = 1;
  logic [5:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;
  logic [1:0]   tile_idle = 2'b11;
  logic         req_ready, resp_valid, resp_err, cfg_freeze, cfg_update, commit_busy;
  logic [31:0]  resp_rdata;
  logic [255:0] cfg_active;

  int nvec = 0, nfail = 0;

  runtime_config_regs #(.N_TILES(2), .RESET_VALUES(RV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .tile_idle(tile_idle), .cfg_freeze(cfg_freeze),
    .cfg_update(cfg_update), .cfg_active(cfg_active), .commit_busy(commit_busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 30) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Reference model: whole-transaction view of the bank.
  logic [31:0] m_shadow [8];
  logic [31:0] m_active [8];
  int          m_phase;      // 0 idle, 1 draining, 2 applying, 3 done
  int          m_left;
  bit          m_tmo, m_err, m_on = 0, m_rv, m_rerr;
  logic [7:0]  m_gen;
  logic [31:0] m_rdata;

  always @(posedge clk) begin : mdl
    bit rdy, acc, legal;
    int a, ph;
    logic [31:0] val;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_shadow[i] = RV[i*32 +: 32]; m_active[i] = RV[i*32 +: 32]; end
      m_phase = 0; m_left = 0; m_tmo = 0; m_err = 0; m_gen = 0; m_rv = 0; m_rerr = 0; m_rdata = 0;
      m_on = 1;
    end else if (m_on) begin
      ph  = m_phase;
      a   = int'(req_addr);
      rdy = (!m_rv || resp_ready) && !(req_write && ph != 0);
      acc = req_valid && rdy;
      if (acc) begin
        val = 0;
        if (req_write) legal = (a == 2) || (a >= 4 && a < 12);
        else begin
          legal = (a == 0) || (a == 1) || (a >= 4 && a < 12);
          if (a == 0) val = 10;
          else if (a == 1) val = {16'h0, m_gen, 5'h0, m_err, 2'(ph)};
          else if (legal) val = m_shadow[a-4];
        end
        m_rv = 1; m_rerr = !legal; m_rdata = legal ? val : 0;
      end else if (resp_ready) m_rv = 0;
      case (ph)
        1: if (tile_idle == 2'b11) m_phase = 2;
           else if (m_tmo) begin
             m_left--;
             if (m_left == 0) begin m_err = 1; m_phase = 0; end
           end
        2: begin
             for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
             m_gen++; m_err = 0; m_phase = 3;
           end
        3: m_phase = 0;
        default: ;
      endcase
      if (acc && req_write && a >= 4 && a < 12) m_shadow[a-4] = req_wdata;
      if (acc && req_write && a == 2) begin
        m_phase = 1; m_left = int'(req_wdata[15:0]); m_tmo = (m_left != 0);
      end
    end
  end

  always begin : cmp
    logic [255:0] exp_act;
    @(negedge clk); #2;
    if (m_on) begin
      for (int i = 0; i < 8; i++) exp_act[i*32 +: 32] = m_active[i];
      chk("req_ready",   req_ready,   (!m_rv || resp_ready) && !(req_write && m_phase != 0));
      chk("resp_valid",  resp_valid,  m_rv);
      if (m_rv) begin
        chk("resp_rdata", resp_rdata, m_rdata);
        chk("resp_err",   resp_err,   m_rerr);
      end
      chk("cfg_freeze",  cfg_freeze,  m_phase != 0);
      chk("commit_busy", commit_busy, m_phase != 0);
      chk("cfg_update",  cfg_update,  m_phase == 3);
      chk("cfg_active",  cfg_active,  exp_act);
    end
  end

  task automatic access(input bit w, input int a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
    int n = 0;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = 6'(a); req_wdata = d;
    #1;
    while (!req_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (!req_ready) begin
      nvec++; nfail++;
      $display("FAIL accept_timeout: req_ready got 0, want 1");
    end
    @(negedge clk);
    req_valid = 0; #1;
    rd = resp_rdata; er = resp_err;
  endtask

  task automatic count_commit(output int f, output int u);
    f = 0; u = 0;
    for (int i = 0; i < 12; i++) begin
      if (cfg_freeze) f++;
      if (cfg_update) u++;
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (commit_busy && n < 30) begin @(negedge clk); #1; n++; end
    chk("busy_bound", commit_busy, 1'b0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          f, u;
    repeat (2) @(negedge clk);
    rst = 0; #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_freeze", cfg_freeze, 1'b0);
    chk("rst_busy", commit_busy, 1'b0);
    chk("rst_active", cfg_active, RV);

    access(0, 0, 0, rd, er);
    chk("version", rd, 32'd10); chk("version_err", er, 1'b0);
    access(0, 4, 0, rd, er);
    chk("shadow0_reset", rd, 32'h1000_0000);

    access(1, 5, 32'hA5A5_0001, rd, er);
    chk("wr5_err", er, 1'b0);
    access(0, 5, 0, rd, er);
    chk("rd5", rd, 32'hA5A5_0001);
    chk("active1_pre", cfg_active[32 +: 32], 32'h1000_0001);

    // Immediate commit with all tiles idle.
    access(1, 2, 0, rd, er);
    count_commit(f, u);
    chk("commit_freeze_cycles", 32'(f), 32'd3);
    chk("commit_update_pulses", 32'(u), 32'd1);
    chk("active1_post", cfg_active[32 +: 32], 32'hA5A5_0001);
    access(0, 1, 0, rd, er);
    chk("status_gen1", rd, 32'h0000_0100);

    // Drain timeout with one tile never idle; a write during drain must stall.
    tile_idle = 2'b01;
    access(1, 2, 32'd5, rd, er);
    req_valid = 1; req_write = 1; req_addr = 6'd4; req_wdata = 32'hDEAD_0000;
    #1;
    chk("drain_write_ready", req_ready, 1'b0);
    req_valid = 0;
    count_commit(f, u);
    chk("tmo_freeze_cycles", 32'(f), 32'd5);
    chk("tmo_update_pulses", 32'(u), 32'd0);
    access(0, 1, 0, rd, er);
    chk("status_tmo", rd, 32'h0000_0104);
    chk("active1_tmo", cfg_active[32 +: 32], 32'hA5A5_0001);
    access(0, 4, 0, rd, er);
    chk("shadow0_after_tmo", rd, 32'h1000_0000);

    // Illegal accesses.
    access(1, 1, 32'hFFFF_FFFF, rd, er); chk("wr_status_err", er, 1'b1);
    access(0, 2, 0, rd, er);             chk("rd_commit_err", er, 1'b1); chk("rd_commit_data", rd, 32'h0);
    access(0, 3, 0, rd, er);             chk("rd_rsvd_err", er, 1'b1);
    access(1, 63, 32'h1, rd, er);        chk("wr63_err", er, 1'b1);
    access(0, 63, 0, rd, er);            chk("rd63_err", er, 1'b1);
    access(0, 1, 0, rd, er);             chk("status_unchanged", rd, 32'h0000_0104);

    // Response back-pressure: response held, no new request accepted.
    @(negedge clk);
    resp_ready = 0; req_valid = 1; req_write = 1; req_addr = 6'd63; req_wdata = 32'h5;
    @(negedge clk);
    req_write = 0; req_addr = 6'd0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_err", resp_err, 1'b1);
      chk("hold_rdata", resp_rdata, 32'h0);
      chk("hold_ready", req_ready, 1'b0);
      @(negedge clk);
    end
    resp_ready = 1; req_valid = 0;

    // Idle arrives on the very cycle the counter would expire.
    tile_idle = 2'b10;
    access(1, 2, 32'd3, rd, er);
    @(negedge clk);
    @(negedge clk);
    tile_idle = 2'b11;
    wait_idle();
    access(0, 1, 0, rd, er);
    chk("status_idle_wins", rd, 32'h0000_0200);

    // Generation wrap after 256 successful commits in total.
    access(1, 4, 32'h1234_5678, rd, er);
    access(1, 11, 32'hFFFF_0000, rd, er);
    for (int k = 0; k < 254; k++) begin
      access(1, 2, 0, rd, er);
      wait_idle();
    end
    access(0, 1, 0, rd, er);
    chk("status_gen_wrap", rd, 32'h0000_0000);
    chk("active0_wrap", cfg_active[0 +: 32], 32'h1234_5678);
    chk("active7_wrap", cfg_active[224 +: 32], 32'hFFFF_0000);

    // Reset in the middle of an endless drain.
    tile_idle = 2'b01;
    access(1, 6, 32'hDEAD_BEEF, rd, er);
    access(1, 2, 0, rd, er);
    @(negedge clk);
    rst = 1;
    @(negedge clk); #1;
    chk("rst_drain_freeze", cfg_freeze, 1'b0);
    chk("rst_drain_busy", commit_busy, 1'b0);
    chk("rst_drain_active", cfg_active, RV);
    rst = 0;
    access(0, 6, 0, rd, er);
    chk("shadow2_after_rst", rd, 32'h1000_0002);
    access(0, 1, 0, rd, er);
    chk("status_after_rst", rd, 32'h0000_0000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
